// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg
//   Shared AXI-lite definitions for the data SRAM responder:
//   response codes, read/write FSM state types and a byte-strobe merge
//   helper for callers that build a merged word themselves.
package axi_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // Replace the strobed byte lanes of old_word with those of new_word.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dsram_mem.sv
// dsram_mem
//   Word-organised storage with one registered read port and one
//   byte-masked synchronous write port. Kept separate so a vendor RAM
//   or simulation model can be dropped in without touching the FSMs.
//   A read and a write to the same word on the same edge return the
//   old contents (read-before-write).
// Ports:
//   clk        clock
//   i_rd_en    sample r_mem[i_rd_addr] into o_rd_data on this edge
//   i_rd_addr  read word index
//   o_rd_data  registered read data, holds until the next i_rd_en
//   i_wr_en    commit a write on this edge
//   i_wr_addr  write word index
//   i_wr_data  write data
//   i_wr_strb  byte-lane enables for the write
module dsram_mem #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data,
  input  logic [3:0]    i_wr_strb
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

  // Per-lane write enables map onto block-RAM byte-write enables.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_wr_en && i_wr_strb[b]) r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/dsram.sv
// dsram
//   AXI-lite responder data SRAM for the load/store unit. Independent
//   read and write FSMs share one dsram_mem instance. Each channel has a
//   fixed access latency; addresses outside [BASE_ADDR, BASE_ADDR+DEPTH*4)
//   return DECERR (reads give zero data, writes change nothing).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   araddr/arvalid/arready        read address channel
//   rdata/rresp/rvalid/rready     read data channel
//   awaddr/awvalid/awready        write address channel
//   wdata/wstrb/wvalid/wready     write data channel
//   bresp/bvalid/bready           write response channel

// Bus-width macros normally come from defines.svh; fall back to the
// standard widths when that header has not been pulled in.
`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS 31:0
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS 31:0
`endif
`ifndef AXI_RESP_BUS
`define AXI_RESP_BUS 1:0
`endif

module dsram
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH      = 4096,
  parameter int          RD_LATENCY = 1,
  parameter int          WR_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`AXI_ADDR_BUS]  araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [`AXI_DATA_BUS]  rdata,
  output logic [`AXI_RESP_BUS]  rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [`AXI_ADDR_BUS]  awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [`AXI_DATA_BUS]  wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [`AXI_RESP_BUS]  bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [32:0] SPAN   = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  RD_LAT = 4'(RD_LATENCY);
  localparam logic [3:0]  WR_LAT = 4'(WR_LATENCY);

  // Offsets are unsigned, so addresses below BASE_ADDR wrap to huge
  // values and fail the range test as well.
  function automatic logic off_ok(input logic [31:0] off);
    return {1'b0, off} < SPAN;
  endfunction

  // ---------------- read channel ----------------
  rd_state_t   r_rd_state, w_rd_state_next;
  logic [3:0]  r_rd_cnt;
  logic [AW-1:0] r_rd_idx, w_rd_idx;
  logic        r_rd_ok;
  logic        w_rd_sample;
  logic [31:0] w_ar_off;
  logic [31:0] w_mem_q;

  assign w_ar_off = araddr - BASE_ADDR;

  always_comb begin
    w_rd_state_next = r_rd_state;
    w_rd_sample     = 1'b0;
    w_rd_idx        = r_rd_idx;
    case (r_rd_state)
      R_IDLE: begin
        if (arvalid) begin
          w_rd_idx = w_ar_off[AW+1:2];
          if (RD_LAT == 4'd0) begin
            w_rd_state_next = R_RESP;
            w_rd_sample     = 1'b1;
          end else begin
            w_rd_state_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_rd_cnt == 4'd1) begin
          w_rd_state_next = R_RESP;
          w_rd_sample     = 1'b1;
        end
      end
      R_RESP: begin
        if (rready) w_rd_state_next = R_IDLE;
      end
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= 4'd0;
      r_rd_idx   <= '0;
      r_rd_ok    <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_next;
      if (r_rd_state == R_IDLE && arvalid) begin
        r_rd_idx <= w_ar_off[AW+1:2];
        r_rd_ok  <= off_ok(w_ar_off);
        r_rd_cnt <= RD_LAT;
      end else if (r_rd_state == R_WAIT) begin
        r_rd_cnt <= r_rd_cnt - 4'd1;
      end
    end
  end

  assign arready = (r_rd_state == R_IDLE);
  assign rvalid  = (r_rd_state == R_RESP);
  assign rresp   = (rvalid && !r_rd_ok) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
  // RAM output holds between samples, so rdata is stable under stall.
  assign rdata   = (rvalid && r_rd_ok) ? w_mem_q : 32'd0;

  // ---------------- write channel ----------------
  wr_state_t   r_wr_state, w_wr_state_next;
  logic [3:0]  r_wr_cnt;
  logic        r_aw_held, r_w_held;
  logic [AW-1:0] r_wr_idx;
  logic        r_wr_ok;
  logic [31:0] r_wr_data;
  logic [3:0]  r_wr_strb;
  logic        w_aw_hs, w_w_hs, w_both;
  logic [31:0] w_aw_off;
  logic [AW-1:0] w_wr_idx_eff;
  logic        w_wr_ok_eff;
  logic [31:0] w_wr_data_eff;
  logic [3:0]  w_wr_strb_eff;
  logic        w_commit, w_mem_we;

  assign w_aw_off = awaddr - BASE_ADDR;
  assign w_aw_hs  = awvalid && awready;
  assign w_w_hs   = wvalid && wready;
  // A beat arriving this cycle counts as held, so AW+W together with
  // zero latency can commit on the very edge that captures them.
  assign w_both   = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  assign w_wr_idx_eff  = r_aw_held ? r_wr_idx  : w_aw_off[AW+1:2];
  assign w_wr_ok_eff   = r_aw_held ? r_wr_ok   : off_ok(w_aw_off);
  assign w_wr_data_eff = r_w_held  ? r_wr_data : wdata;
  assign w_wr_strb_eff = r_w_held  ? r_wr_strb : wstrb;

  always_comb begin
    w_wr_state_next = r_wr_state;
    w_commit        = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (w_both) begin
          if (WR_LAT == 4'd0) begin
            w_wr_state_next = W_RESP;
            w_commit        = 1'b1;
          end else begin
            w_wr_state_next = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (r_wr_cnt == 4'd1) begin
          w_wr_state_next = W_RESP;
          w_commit        = 1'b1;
        end
      end
      W_RESP: begin
        if (bready) w_wr_state_next = W_IDLE;
      end
      default: w_wr_state_next = W_IDLE;
    endcase
  end

  // Reset on the commit edge must leave the array untouched.
  assign w_mem_we = w_commit && w_wr_ok_eff && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_cnt   <= 4'd0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_wr_idx   <= '0;
      r_wr_ok    <= 1'b0;
      r_wr_data  <= 32'd0;
      r_wr_strb  <= 4'd0;
    end else begin
      r_wr_state <= w_wr_state_next;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_wr_idx  <= w_aw_off[AW+1:2];
        r_wr_ok   <= off_ok(w_aw_off);
      end
      if (w_w_hs) begin
        r_w_held  <= 1'b1;
        r_wr_data <= wdata;
        r_wr_strb <= wstrb;
      end
      if (r_wr_state == W_IDLE && w_both) begin
        r_wr_cnt <= WR_LAT;
      end else if (r_wr_state == W_WAIT) begin
        r_wr_cnt <= r_wr_cnt - 4'd1;
      end
      if (r_wr_state == W_RESP && bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  assign awready = (r_wr_state == W_IDLE) && !r_aw_held;
  assign wready  = (r_wr_state == W_IDLE) && !r_w_held;
  assign bvalid  = (r_wr_state == W_RESP);
  assign bresp   = (bvalid && !r_wr_ok) ? AXI_RESP_DECERR : AXI_RESP_OKAY;

  dsram_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_rd_en   (w_rd_sample),
    .i_rd_addr (w_rd_idx),
    .o_rd_data (w_mem_q),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (w_wr_idx_eff),
    .i_wr_data (w_wr_data_eff),
    .i_wr_strb (w_wr_strb_eff)
  );

endmodule

// File: tb/tb_dsram.sv
// tb_dsram
//   Self-checking bench for dsram: reset state, a table of directed
//   transactions, randomized traffic against a word-array model, and
//   hand-built sequences for ordering, back-pressure, collision and reset.
module tb_dsram;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 4096;
  localparam int          RD_LAT = 1;
  localparam int          WR_LAT = 1;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  DECERR = 2'b11;

  logic        clk, rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  dsram #(
    .BASE_ADDR  (BASE),
    .DEPTH      (DEPTH),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word index -> contents, only for words written.
  bit [31:0] mdl [int];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint off;
    off = longint'({32'd0, a}) - longint'({32'd0, BASE});
    return (off >= 0) && (off < longint'(DEPTH) * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic bit [31:0] mdl_merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] s);
    bit [31:0] m;
    m = 32'd0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
    return (o & ~m) | (n & m);
  endfunction

  function automatic bit [31:0] mdl_get(input int idx);
    return mdl.exists(idx) ? mdl[idx] : 32'd0;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    int lat;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    while (!bvalid && lat < 40) begin
      tick();
      lat++;
    end
    chk("wr_bvalid_seen", 32'(bvalid), 32'd1);
    chk("wr_latency", 32'(lat), 32'(1 + WR_LAT));
    chk("wr_bresp", 32'(bresp), 32'(exp_resp));
    if (in_rng(addr)) mdl[widx(addr)] = mdl_merge(mdl_get(widx(addr)), data, strb);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("wr_bvalid_drop", 32'(bvalid), 32'd0);
    chk("wr_awready_back", 32'(awready & wready), 32'd1);
    $display("[TB] WR addr=%h data=%h strb=%h bresp=%0d lat=%0d", addr, data, strb, bresp, lat);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] exp_resp,
                         input logic [31:0] exp_data);
    int lat;
    logic [31:0] got;
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 40) begin
      tick();
      lat++;
    end
    got = rdata;
    chk("rd_rvalid_seen", 32'(rvalid), 32'd1);
    chk("rd_latency", 32'(lat), 32'(1 + RD_LAT));
    chk("rd_rresp", 32'(rresp), 32'(exp_resp));
    chk("rd_rdata", got, exp_data);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rd_rvalid_drop", 32'(rvalid), 32'd0);
    chk("rd_arready_back", 32'(arready), 32'd1);
    $display("[TB] RD addr=%h rdata=%h rresp=%0d lat=%0d", addr, got, exp_resp, lat);
  endtask

  initial begin
    logic [31:0] a, d, old_v, new_v, got;
    logic [1:0]  er;
    int          cnt;
    bit          seen_r, seen_b;

    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // ---- reset state ----
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready",  32'(wready),  32'd1);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_rresp",   32'(rresp),   32'd0);
    chk("rst_bresp",   32'(bresp),   32'd0);

    // ---- directed table ----
    vt[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, OKAY,   32'd0};
    vt[1]  = '{1'b0, 32'h8000_0010, 32'd0,         4'h0, OKAY,   32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, OKAY,   32'd0};
    vt[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, OKAY,   32'd0};
    vt[4]  = '{1'b0, 32'h8000_0020, 32'd0,         4'h0, OKAY,   32'h11BB_33DD};
    vt[5]  = '{1'b0, 32'h7FFF_FFFC, 32'd0,         4'h0, DECERR, 32'd0};
    vt[6]  = '{1'b1, 32'h8000_3FFC, 32'h5566_7788, 4'hF, OKAY,   32'd0};
    vt[7]  = '{1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, DECERR, 32'd0};
    vt[8]  = '{1'b0, 32'h8000_3FFC, 32'd0,         4'h0, OKAY,   32'h5566_7788};
    vt[9]  = '{1'b1, 32'h8000_0022, 32'h0000_0000, 4'h0, OKAY,   32'd0};
    vt[10] = '{1'b0, 32'h8000_0020, 32'd0,         4'h0, OKAY,   32'h11BB_33DD};
    vt[11] = '{1'b0, 32'h8000_0023, 32'd0,         4'h0, OKAY,   32'h11BB_33DD};
    vt[12] = '{1'b0, 32'hFFFF_FFFC, 32'd0,         4'h0, DECERR, 32'd0};
    vt[13] = '{1'b0, 32'h8000_4000, 32'd0,         4'h0, DECERR, 32'd0};
    for (int i = 0; i < 14; i++) begin
      if (vt[i].is_wr) do_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].resp);
      else             do_read(vt[i].addr, vt[i].resp, vt[i].rdata);
    end

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 32; i++) do_write(BASE + 32'(i * 4), $urandom, 4'hF, OKAY);
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 63) * 4);
        1:       a = BASE - 32'(4 * (1 + $urandom_range(0, 15)));
        default: a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      endcase
      er = in_rng(a) ? OKAY : DECERR;
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)), er);
      end else begin
        d = in_rng(a) ? mdl_get(widx(a)) : 32'd0;
        do_read(a, er, d);
      end
    end

    // ---- W beat three cycles ahead of AW ----
    a = BASE + 32'h40;
    do_write(a, 32'h0BAD_F00D, 4'hF, OKAY);
    wdata = 32'h1357_9BDF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("ord_wready_low", 32'(wready), 32'd0);
    chk("ord_awready_high", 32'(awready), 32'd1);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    chk("ord_rvalid", 32'(rvalid), 32'd1);
    chk("ord_no_early_commit", rdata, 32'h0BAD_F00D);
    chk("ord_no_early_bvalid", 32'(bvalid), 32'd0);
    awaddr = a; awvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; rready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bvalid) cnt++;
      tick();
    end
    bready = 1'b0;
    chk("ord_one_bpulse", 32'(cnt), 32'd1);
    mdl[widx(a)] = 32'h1357_9BDF;
    do_read(a, OKAY, 32'h1357_9BDF);

    // ---- rready held low while the write channel completes ----
    a = BASE + 32'h14;
    old_v = mdl_get(widx(a));
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    cnt = 0;
    while (!rvalid && cnt < 40) begin
      tick();
      cnt++;
    end
    new_v = $urandom;
    awaddr = BASE + 32'h18; wdata = new_v; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    seen_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid_hold", 32'(rvalid), 32'd1);
      chk("bp_rdata_hold", rdata, old_v);
      chk("bp_arready_low", 32'(arready), 32'd0);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      if (bvalid) seen_b = 1'b1;
    end
    bready = 1'b0;
    chk("bp_write_done", 32'(seen_b), 32'd1);
    mdl[widx(BASE + 32'h18)] = new_v;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("bp_rvalid_drop", 32'(rvalid), 32'd0);
    do_read(BASE + 32'h18, OKAY, new_v);

    // ---- same-edge read sample and write commit ----
    a = BASE + 32'h1C;
    old_v = mdl_get(widx(a));
    new_v = ~old_v;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    awaddr = a; wdata = new_v; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    seen_r = 1'b0; seen_b = 1'b0; got = 32'd0;
    for (int i = 0; i < 8; i++) begin
      if (rvalid && !seen_r) begin
        got = rdata;
        seen_r = 1'b1;
      end
      if (bvalid) seen_b = 1'b1;
      tick();
    end
    rready = 1'b0; bready = 1'b0;
    chk("col_rvalid_seen", 32'(seen_r), 32'd1);
    chk("col_bvalid_seen", 32'(seen_b), 32'd1);
    chk("col_old_data", got, old_v);
    mdl[widx(a)] = new_v;
    do_read(a, OKAY, new_v);

    // ---- reset while both channels wait ----
    a = BASE + 32'h20;
    old_v = mdl_get(widx(a));
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    awaddr = a; wdata = ~old_v; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd1);
    chk("mid_rst_awready", 32'(awready), 32'd1);
    chk("mid_rst_wready", 32'(wready), 32'd1);
    tick();
    chk("mid_rst_no_late_resp", 32'(rvalid | bvalid), 32'd0);
    do_read(a, OKAY, old_v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dsram.md
Name: dsram

Overview:
- AXI-lite responder (slave) data SRAM serving the lsu load/store master.
- Pairs with the lsu master port the same way isram serves fetch, but implements both the read and the write channels.
- Holds a word-organised storage array with byte-lane write strobes, fixed configurable access latency, and decode-error responses for out-of-range addresses.
- Read and write channels run independently and concurrently.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH, 4096, number of 32-bit words; power of two.
- RD_LATENCY, 1, wait cycles between AR handshake and rvalid assertion (0..15).
- WR_LATENCY, 1, wait cycles between the AW+W pair being complete and bvalid assertion (0..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- araddr  in  32  read address (`AXI_ADDR_BUS).
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data (`AXI_DATA_BUS).
- rresp  out  2  read response (`AXI_RESP_BUS).
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  32  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte-lane strobes; bit i enables wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Both FSMs go to IDLE.
  - Outputs become: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - Storage contents are not cleared.
  - Reset mid-transaction drops the transaction; no response is issued and no partial write occurs.
- Handshake rule: a transfer occurs on any edge where valid&&ready. Outputs are registered. rdata, rresp, bresp stay stable while valid && !ready.
- Address decode:
  - off = addr - BASE_ADDR.
  - In range iff off < DEPTH*4. Word index = off[log2(DEPTH)+1:2]. addr[1:0] is ignored.
  - Response codes: OKAY=2'b00, DECERR=2'b11.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1. On AR handshake, latch the address and load the counter with RD_LATENCY.
    - Latency 0: go to R_RESP.
    - Otherwise: go to R_WAIT.
  - R_WAIT: arready=0. Counter decrements each cycle; at 1, go to R_RESP. Memory is sampled on the edge entering R_RESP.
  - R_RESP: rvalid=1, rdata=word (0 when out of range), rresp=OKAY or DECERR.
    - On R handshake, return to R_IDLE; arready rises the next cycle.
    - Back-to-back AR cannot overlap.
  - Timing: AR handshake at cycle 0 gives rvalid at cycle 1+RD_LATENCY.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: AW and W are accepted independently, in either order or in the same cycle.
    - Each side's ready drops once its beat is captured.
  - When both beats are held, load the counter with WR_LATENCY.
    - Latency 0: go to W_RESP, committing the write on that edge.
    - Otherwise: go to W_WAIT.
  - W_WAIT: counter decrements; at 1, commit the write and go to W_RESP.
  - Commit updates only the strobed bytes. wstrb=0 is a legal no-op that still gets an OKAY response. Out-of-range writes modify nothing and respond DECERR.
  - W_RESP: bvalid=1. On B handshake, go to W_IDLE and re-raise awready and wready.
- Collisions and back-pressure:
  - Same-edge read sample and write commit to the same word: the read returns the old data (read-before-write).
  - No ordering is guaranteed between the channels.
  - rready or bready held low stalls only its own channel indefinitely. The other channel continues.

Decomposition:
- Package axi_lite_pkg holds:
  - resp constants AXI_RESP_OKAY, AXI_RESP_SLVERR, AXI_RESP_DECERR;
  - rd_state_t and wr_state_t enums;
  - a helper function for byte-strobe merge.
- Bus widths use the existing `AXI_* macros from defines.svh.
- One sub-module, dsram_mem: 1 read port, 1 byte-masked write port, synchronous write, registered read. It isolates storage so an FPGA/DPI replacement is drop-in.

Test Plan:
- Write then read: AW=0x8000_0010 and W=0xDEAD_BEEF with wstrb=4'hF in the same cycle. Expect bvalid at cycle 1+WR_LATENCY with bresp=00. Then AR to the same address gives rdata=0xDEAD_BEEF, rresp=00, with rvalid at cycle 1+RD_LATENCY.
- Partial strobe: word preloaded 0x1122_3344; write wdata=0xAABB_CCDD with wstrb=4'b0101. Read returns 0x11BB_33DD.
- AW/W ordering: W handshake 3 cycles before AW. Expect wready=0 after the W beat, the write commits only after AW arrives, and exactly one bvalid pulse is issued.
- Decode error: AR to 0x7FFF_FFFC gives rresp=11 and rdata=0. Write to BASE_ADDR+DEPTH*4 gives bresp=11, and a read of word DEPTH-1 is unchanged.
- Back-pressure and collision:
  - rready held low for 5 cycles: rvalid/rdata stay stable and arready stays 0; the write channel completes meanwhile.
  - Same-edge read/write to one word: the read returns old data.
- Reset mid-op: assert rst while in R_WAIT and W_WAIT. Next cycle rvalid=bvalid=0 and arready=awready=wready=1, with no memory change.
